// File: rtl/dmac_read_requester.sv
// rtl/dmac_read_requester.sv - DMA read-address stage: splits a read command into 4 KB-safe AXI4 INCR bursts
module dmac_read_requester #(
    parameter int ADDR_WD         = 32,
    parameter int DATA_WD         = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LEN_WD          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [LEN_WD-1:0]  cmd_len,
    output logic               busy,
    output logic               done,
    input  logic               rd_resp_valid,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    output logic [ADDR_WD-1:0] m_axi_araddr,
    output logic [7:0]         m_axi_arlen,
    output logic [2:0]         m_axi_arsize,
    output logic [1:0]         m_axi_arburst
);

    localparam int STRB_WD    = DATA_WD / 8;
    localparam int SIZE_SHIFT = $clog2(STRB_WD);
    localparam int OUT_WD     = $clog2(MAX_OUTSTANDING + 1);
    // 13 bits hold 4096; one extra bit keeps the min() comparisons unsigned-safe
    localparam int CW         = ((LEN_WD > 13) ? LEN_WD : 13) + 1;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_t;

    state_t             state;
    logic [ADDR_WD-1:0] addr;
    logic [LEN_WD-1:0]  remaining;
    logic [OUT_WD-1:0]  outstanding;
    logic [CW-1:0]      burst_q;
    logic [CW-1:0]      page_beats;
    logic [CW-1:0]      burst_calc;
    logic               ar_hs;
    logic               resp_dec;

    assign m_axi_arsize  = 3'(SIZE_SHIFT);
    assign m_axi_arburst = 2'b01;
    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign done          = (state == DRAIN) && (outstanding == '0);
    assign ar_hs         = m_axi_arvalid && m_axi_arready;
    assign resp_dec      = rd_resp_valid && (outstanding != '0);

    // Burst length: the smallest of remaining beats, the burst cap and beats left in this 4 KB page
    always_comb begin
        page_beats = (CW'(4096) - CW'(addr[11:0])) >> SIZE_SHIFT;
        burst_calc = CW'(remaining);
        if (CW'(MAX_BURST_LEN) < burst_calc) begin
            burst_calc = CW'(MAX_BURST_LEN);
        end
        if (page_beats < burst_calc) begin
            burst_calc = page_beats;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({ar_hs, resp_dec})
                2'b10:   outstanding <= outstanding + OUT_WD'(1);
                2'b01:   outstanding <= outstanding - OUT_WD'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            burst_q       <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr      <= cmd_addr & ~ADDR_WD'(STRB_WD - 1);
                        remaining <= cmd_len;
                        state     <= (cmd_len == '0) ? DRAIN : CALC;
                    end
                end
                CALC: begin
                    if (outstanding != OUT_WD'(MAX_OUTSTANDING)) begin
                        m_axi_araddr  <= addr;
                        m_axi_arlen   <= 8'(burst_calc - CW'(1));
                        burst_q       <= burst_calc;
                        m_axi_arvalid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        addr          <= addr + (ADDR_WD'(burst_q) << SIZE_SHIFT);
                        remaining     <= remaining - LEN_WD'(burst_q);
                        state         <= (remaining == LEN_WD'(burst_q)) ? DRAIN : CALC;
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completion with nothing outstanding means the handler and this stage disagree
    assert property (@(posedge clk) disable iff (rst) !(rd_resp_valid && (outstanding == '0)))
        else $error("rd_resp_valid with no burst outstanding");

endmodule

// File: tb/tb_dmac_read_requester.sv
// tb/tb_dmac_read_requester.sv - directed self-checking bench for dmac_read_requester
module tb_dmac_read_requester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        busy;
    logic        done;
    logic        rd_resp_valid;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;

    int n_cmp  = 0;
    int n_fail = 0;
    int ar_cnt = 0;
    int resp_cnt = 0;
    int done_cnt = 0;
    int ar_base, resp_base, done_base;

    logic       auto_resp   = 1'b0;
    logic       manual_resp = 1'b0;
    logic [3:0] resp_pipe   = '0;

    assign rd_resp_valid = manual_resp | resp_pipe[3];

    dmac_read_requester #(
        .ADDR_WD(32), .DATA_WD(32), .MAX_BURST_LEN(16), .MAX_OUTSTANDING(2), .LEN_WD(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done), .rd_resp_valid(rd_resp_valid),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst)
    );

    always #5 clk = ~clk;

    // Response model: each burst completes 4 cycles after its AR handshake
    always @(posedge clk) begin
        if (rst) resp_pipe <= '0;
        else     resp_pipe <= {resp_pipe[2:0], auto_resp && m_axi_arvalid && m_axi_arready};
        if (m_axi_arvalid && m_axi_arready) ar_cnt <= ar_cnt + 1;
        if (rd_resp_valid) resp_cnt <= resp_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        ar_base   = ar_cnt;
        resp_base = resp_cnt;
        done_base = done_cnt;
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic [15:0] l);
        chk("cmd_ready before cmd", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_BEEF;
        cmd_len   = 16'hFFFF;
    endtask

    task automatic wait_ar(input string tag, input logic [31:0] ea, input logic [7:0] el,
                           input logic co_resp);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_axi_arvalid && m_axi_arready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, " handshake"}, 32'(got), 1);
        chk({tag, " araddr"}, m_axi_araddr, ea);
        chk({tag, " arlen"}, 32'(m_axi_arlen), 32'(el));
        if (co_resp) manual_resp = 1'b1;
        tick();
        manual_resp = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_resp, input int exp_ar);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, " done seen"}, 32'(got), 1);
        chk({tag, " resp before done"}, resp_cnt - resp_base, exp_resp);
        chk({tag, " ar count"}, ar_cnt - ar_base, exp_ar);
        tick();
        chk({tag, " done one cycle"}, 32'(done), 0);
        chk({tag, " idle after done"}, 32'(busy), 0);
        tick();
        chk({tag, " single done"}, done_cnt - done_base, 1);
    endtask

    initial begin
        logic got;
        // Reset values
        tick();
        chk("rst arvalid", 32'(m_axi_arvalid), 0);
        chk("rst araddr", m_axi_araddr, 0);
        chk("rst arlen", 32'(m_axi_arlen), 0);
        chk("rst done", 32'(done), 0);
        chk("rst busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post-rst cmd_ready", 32'(cmd_ready), 1);

        // Basic split: 40 beats from 0x1000
        m_axi_arready = 1'b1;
        auto_resp = 1'b1;
        mark();
        send_cmd(32'h1000, 16'd40);
        chk("t1 busy", 32'(busy), 1);
        chk("t1 cmd_ready", 32'(cmd_ready), 0);
        wait_ar("t1 ar0", 32'h1000, 8'd15, 1'b0);
        chk("t1 arsize", 32'(m_axi_arsize), 2);
        chk("t1 arburst", 32'(m_axi_arburst), 1);
        wait_ar("t1 ar1", 32'h1040, 8'd15, 1'b0);
        wait_ar("t1 ar2", 32'h1080, 8'd7, 1'b0);
        wait_done("t1", 3, 3);

        // 4 KB boundary crossing
        mark();
        send_cmd(32'h0FF0, 16'd8);
        wait_ar("t2 ar0", 32'h0FF0, 8'd3, 1'b0);
        wait_ar("t2 ar1", 32'h1000, 8'd3, 1'b0);
        wait_done("t2", 2, 2);

        // Outstanding limit of 2 with no responses
        auto_resp = 1'b0;
        mark();
        send_cmd(32'h1000, 16'd64);
        wait_ar("t3 ar0", 32'h1000, 8'd15, 1'b0);
        wait_ar("t3 ar1", 32'h1040, 8'd15, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_axi_arvalid) got = 1'b1;
            tick();
        end
        chk("t3 stall no arvalid", 32'(got), 0);
        chk("t3 stall ar count", ar_cnt - ar_base, 2);
        chk("t3 stall busy", 32'(busy), 1);
        manual_resp = 1'b1;
        tick();
        manual_resp = 1'b0;
        wait_ar("t3 ar2", 32'h1080, 8'd15, 1'b0);
        manual_resp = 1'b1;
        tick();
        manual_resp = 1'b0;
        wait_ar("t3 ar3 coincident", 32'h10C0, 8'd15, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("t3 no early done", done_cnt - done_base, 0);
        chk("t3 still busy", 32'(busy), 1);
        manual_resp = 1'b1;
        tick();
        manual_resp = 1'b0;
        chk("t3 done after last resp", 32'(done), 1);
        tick();
        chk("t3 idle", 32'(busy), 0);
        chk("t3 done count", done_cnt - done_base, 1);

        // AR back-pressure: arready low for 5 cycles
        auto_resp = 1'b1;
        m_axi_arready = 1'b0;
        mark();
        send_cmd(32'h3000, 16'd4);
        for (int i = 0; i < 10 && !m_axi_arvalid; i++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4 hold arvalid", 32'(m_axi_arvalid), 1);
            chk("t4 hold araddr", m_axi_araddr, 32'h3000);
            chk("t4 hold arlen", 32'(m_axi_arlen), 3);
            tick();
        end
        chk("t4 no hs while low", ar_cnt - ar_base, 0);
        m_axi_arready = 1'b1;
        chk("t4 arvalid at ready", 32'(m_axi_arvalid), 1);
        tick();
        chk("t4 one hs", ar_cnt - ar_base, 1);
        chk("t4 arvalid drops", 32'(m_axi_arvalid), 0);
        wait_done("t4", 1, 1);

        // Zero-length command
        mark();
        send_cmd(32'h5000, 16'd0);
        chk("t5 busy", 32'(busy), 1);
        chk("t5 done", 32'(done), 1);
        chk("t5 cmd_ready low", 32'(cmd_ready), 0);
        chk("t5 arvalid", 32'(m_axi_arvalid), 0);
        tick();
        chk("t5 busy cleared", 32'(busy), 0);
        chk("t5 done cleared", 32'(done), 0);
        chk("t5 cmd_ready", 32'(cmd_ready), 1);
        chk("t5 no ar", ar_cnt - ar_base, 0);
        chk("t5 done count", done_cnt - done_base, 1);

        // Asynchronous reset while an AR is pending
        m_axi_arready = 1'b0;
        mark();
        send_cmd(32'h4000, 16'd16);
        for (int i = 0; i < 10 && !m_axi_arvalid; i++) tick();
        chk("t6 arvalid pre-rst", 32'(m_axi_arvalid), 1);
        rst = 1'b1;
        #1;
        chk("t6 arvalid async", 32'(m_axi_arvalid), 0);
        chk("t6 busy async", 32'(busy), 0);
        chk("t6 araddr async", m_axi_araddr, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("t6 cmd_ready", 32'(cmd_ready), 1);
        tick();
        tick();
        chk("t6 no done", done_cnt - done_base, 0);
        m_axi_arready = 1'b1;
        mark();
        send_cmd(32'h2000, 16'd1);
        wait_ar("t6 ar0", 32'h2000, 8'd0, 1'b0);
        wait_done("t6", 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmac_read_requester.md
Name: dmac_read_requester

Overview:
- Read-address stage of a DMA channel, directly upstream of the read-response handler.
- Accepts one read command per transfer: a start address and a beat count.
- Splits the command into AXI4 INCR bursts of at most MAX_BURST_LEN beats that never cross a 4 KB boundary, and drives the AR channel.
- Limits outstanding bursts using the handler's per-burst completion pulse (rd_resp_valid), and pulses done when every issued burst has returned.

Parameters:
- ADDR_WD, 32, address width.
- DATA_WD, 32, data width; beat size STRB_WD = DATA_WD/8 bytes (power of two, at least 1).
- MAX_BURST_LEN, 16, maximum beats per burst (1..256).
- MAX_OUTSTANDING, 4, maximum bursts issued but not yet completed (at least 1).
- LEN_WD, 16, width of the command beat count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept; high only in IDLE
- cmd_addr  in  ADDR_WD  start byte address; low log2(STRB_WD) bits ignored (treated as 0)
- cmd_len  in  LEN_WD  total beats; 0 is legal
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the transfer completes
- rd_resp_valid  in  1  pulse from the read handler: one burst's last beat accepted
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_araddr  out  ADDR_WD  burst start address
- m_axi_arlen  out  8  beats minus 1
- m_axi_arsize  out  3  constant log2(STRB_WD)
- m_axi_arburst  out  2  constant 2'b01 (INCR)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; arvalid=0, araddr=0, arlen=0, done=0, busy=0.
  - Outstanding counter and remaining-beat counter cleared.
  - cmd_ready=1 once rst deasserts.
  - Reset mid-transfer abandons the transfer; no done pulse.
- FSM states: IDLE, CALC, ISSUE, DRAIN.
- IDLE: on cmd_valid && cmd_ready, latch addr (low bits zeroed) and remaining=cmd_len.
  - cmd_len==0: go to DRAIN; done then pulses in the first DRAIN cycle, since outstanding is 0.
  - Otherwise go to CALC.
- CALC:
  - If outstanding == MAX_OUTSTANDING, stay in CALC.
  - Else compute burst = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) >> log2(STRB_WD)), register araddr=addr and arlen=burst-1, then go to ISSUE.
  - Intermediate arithmetic must be wide enough to hold 4096/STRB_WD and LEN_WD values without truncation.
- ISSUE:
  - arvalid=1; araddr and arlen held stable until arready.
  - On handshake: arvalid drops the next cycle; addr += burst*STRB_WD; remaining -= burst; outstanding++.
  - Next state: DRAIN if remaining==0, else CALC.
- DRAIN: when outstanding==0, assert done for one cycle and return to IDLE in the same transition.
- Minimum spacing is 2 cycles per burst (CALC + ISSUE); back-to-back AR without gaps is not required.
- Outstanding counter:
  - Width clog2(MAX_OUTSTANDING+1).
  - +1 on AR handshake, -1 on rd_resp_valid; both in the same cycle = no change.
  - rd_resp_valid while outstanding==0 is ignored (counter saturates at 0) and flagged by a simulation assertion.
- Address wrap past 2^ADDR_WD is not checked; arithmetic is modulo 2^ADDR_WD.
- cmd_* inputs are ignored outside IDLE.

Test Plan:
- DATA_WD=32, addr=0x1000, len=40, arready=1, each response returned 4 cycles after its AR -> ARs (0x1000, arlen 15), (0x1040, 15), (0x1080, 7); arsize=2, arburst=1; done pulses once, after the 3rd rd_resp_valid.
- 4 KB crossing: addr=0x0FF0, len=8 -> (0x0FF0, arlen 3), then (0x1000, arlen 3); no burst spans 0x1000.
- MAX_OUTSTANDING=2, len=64, no responses -> exactly 2 ARs issued and the FSM stalls in CALC. Pulse rd_resp_valid once -> 3rd AR (0x1080, arlen 15) issued. In a cycle where rd_resp_valid and the AR handshake coincide -> outstanding unchanged.
- arready held low 5 cycles during ISSUE -> arvalid, araddr and arlen stable across all 5 cycles; exactly one handshake occurs.
- len=0 -> no arvalid ever asserted; busy high for 1 cycle; done pulses one cycle after acceptance; cmd_ready high again the next cycle.
- rst asserted mid-ISSUE with arvalid=1 -> arvalid=0 in the same cycle (asynchronous); busy=0; no done pulse; after release, a new command (0x2000, len 1) issues (0x2000, arlen 0).
